// File: rtl/utmi_rx_fsm.sv
// -----------------------------------------------------------------------------
// utmi_rx_fsm
// -----------------------------------------------------------------------------
// Receive-side control for the UTMI block. It takes decoded, unstuffed bit
// strobes from the NRZI-decode/unstuff datapath and assembles them into bytes,
// LSB first. It drives the UTMI receive handshake toward the link/SIE, and the
// enables for the SYNC searcher and the bit unstuffer.
//
// Optional build macro:
//   UTMI_RX_DRIBBLE_EN - when defined, an EOP that arrives with 1..7 bits of a
//                        partial byte ends the packet normally, and the partial
//                        bits are dropped. When undefined, the same EOP gives a
//                        one-cycle RX_Error before the FSM returns to RX_WAIT.
//
// Parameters:
//   TIMEOUT_CYC          clock cycles without a bit strobe in RX_DATA before
//                        the packet is aborted (legal range 2..255)
//
// Ports:
//   clk_i                block clock, rising edge
//   rst_ni               asynchronous, active-low reset
//   sync_detected_i      pulse: SYNC pattern recognised
//   rx_bit_strobe_i      pulse: rx_bit_i holds a valid decoded bit
//   rx_bit_i             decoded data bit, qualified by rx_bit_strobe_i
//   stuff_error_i        pulse: seven consecutive ones detected
//   eop_detected_i       pulse: EOP recognised
//   line_idle_i          level: bus idle (J) for at least 8 bit times
//   rx_active_o          packet in progress toward the SIE
//   rx_valid_o           pulse: rx_data_o holds a new byte
//   rx_data_o            received byte, LSB = first bit on the wire
//   rx_error_o           receive error, level while aborting
//   sync_search_enable_o enables the SYNC pattern detector
//   unstuff_enable_o     enables bit unstuffing in the decode path
// -----------------------------------------------------------------------------
module utmi_rx_fsm #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sync_detected_i,
   input  logic       rx_bit_strobe_i,
   input  logic       rx_bit_i,
   input  logic       stuff_error_i,
   input  logic       eop_detected_i,
   input  logic       line_idle_i,
   output logic       rx_active_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   output logic       rx_error_o,
   output logic       sync_search_enable_o,
   output logic       unstuff_enable_o
);

`ifdef UTMI_RX_DRIBBLE_EN
   localparam logic DRIBBLE_OK = 1'b1;
`else
   localparam logic DRIBBLE_OK = 1'b0;
`endif

   // The abort fires on the cycle in which the counter would reach TIMEOUT_CYC.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      RX_WAIT  = 2'd0,
      RX_DATA  = 2'd1,
      RX_EOP   = 2'd2,
      RX_ABORT = 2'd3
   } state_t;

   state_t     state_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shift_q;
   logic [7:0] tmo_q;
   // Set when the abort was caused by a partial-byte EOP. That abort lasts
   // exactly one cycle, because the EOP it would wait for has already passed.
   logic       abort_once_q;
   logic [7:0] byte_d;

   // The byte as it stands after the current bit is written. At the wrap, this
   // value is the complete byte.
   always_comb begin
      byte_d            = shift_q;
      byte_d[bit_cnt_q] = rx_bit_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q              <= RX_WAIT;
         bit_cnt_q            <= 3'd0;
         shift_q              <= 8'd0;
         tmo_q                <= 8'd0;
         abort_once_q         <= 1'b0;
         rx_active_o          <= 1'b0;
         rx_valid_o           <= 1'b0;
         rx_data_o            <= 8'd0;
         rx_error_o           <= 1'b0;
         sync_search_enable_o <= 1'b1;
         unstuff_enable_o     <= 1'b0;
      end else begin
         rx_valid_o <= 1'b0;
         case (state_q)
            RX_WAIT: begin
               if (sync_detected_i) begin
                  state_q              <= RX_DATA;
                  bit_cnt_q            <= 3'd0;
                  tmo_q                <= 8'd0;
                  rx_active_o          <= 1'b1;
                  unstuff_enable_o     <= 1'b1;
                  sync_search_enable_o <= 1'b0;
               end
            end

            RX_DATA: begin
               // Priority: stuff error, then EOP, then bit strobe, then timeout.
               if (stuff_error_i) begin
                  state_q          <= RX_ABORT;
                  abort_once_q     <= 1'b0;
                  rx_error_o       <= 1'b1;
                  unstuff_enable_o <= 1'b0;
               end else if (eop_detected_i) begin
                  unstuff_enable_o <= 1'b0;
                  if (bit_cnt_q == 3'd0 || DRIBBLE_OK) begin
                     state_q <= RX_EOP;
                  end else begin
                     state_q      <= RX_ABORT;
                     abort_once_q <= 1'b1;
                     rx_error_o   <= 1'b1;
                  end
               end else if (rx_bit_strobe_i) begin
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  tmo_q     <= 8'd0;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_o  <= byte_d;
                     rx_valid_o <= 1'b1;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  state_q          <= RX_ABORT;
                  abort_once_q     <= 1'b0;
                  rx_error_o       <= 1'b1;
                  unstuff_enable_o <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end

            RX_EOP: begin
               state_q              <= RX_WAIT;
               bit_cnt_q            <= 3'd0;
               abort_once_q         <= 1'b0;
               rx_active_o          <= 1'b0;
               rx_error_o           <= 1'b0;
               unstuff_enable_o     <= 1'b0;
               sync_search_enable_o <= 1'b1;
            end

            RX_ABORT: begin
               if (abort_once_q || eop_detected_i || line_idle_i) begin
                  state_q              <= RX_WAIT;
                  bit_cnt_q            <= 3'd0;
                  abort_once_q         <= 1'b0;
                  rx_active_o          <= 1'b0;
                  rx_error_o           <= 1'b0;
                  unstuff_enable_o     <= 1'b0;
                  sync_search_enable_o <= 1'b1;
               end
            end

            default: begin
               state_q              <= RX_WAIT;
               bit_cnt_q            <= 3'd0;
               abort_once_q         <= 1'b0;
               rx_active_o          <= 1'b0;
               rx_error_o           <= 1'b0;
               unstuff_enable_o     <= 1'b0;
               sync_search_enable_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/utmi_rx_fsm.md
Name: utmi_rx_fsm

Overview:
Receive-side control for the UTMI block; the counterpart of the transmit FSM. Consumes decoded, unstuffed bit strobes from the NRZI-decode/unstuff datapath and assembles bytes LSB-first. Drives the UTMI receive handshake (RX_Active, RX_Valid, RX_Error, RX_Data) toward the link/SIE. Also drives the enables for the SYNC searcher and the bit unstuffer.

Parameters:
TIMEOUT_CYC, 64, Clk cycles without a bit strobe in RX_DATA before the packet is aborted (legal range 2..255).

Ports:
Clk  input  1  block clock, rising edge
Rst  input  1  asynchronous, active-low reset
sync_detected  input  1  one-cycle pulse: SYNC pattern recognised (last K of SYNC seen)
rx_bit_strobe  input  1  one-cycle pulse: rx_bit holds a valid decoded, unstuffed bit
rx_bit  input  1  decoded data bit, qualified by rx_bit_strobe
stuff_error  input  1  one-cycle pulse: seven consecutive ones detected
eop_detected  input  1  one-cycle pulse: EOP recognised
line_idle  input  1  level: bus in idle J state for at least 8 bit times
RX_Active  output  1  packet in progress toward SIE
RX_Valid  output  1  one-cycle pulse: RX_Data holds a new byte
RX_Data  output  8  received byte, LSB = first bit on wire
RX_Error  output  1  receive error, level while in RX_ABORT
sync_search_enable  output  1  enables the SYNC pattern detector
unstuff_enable  output  1  enables bit unstuffing in the decode path

Behaviour:
- Reset: all outputs registered and cleared to 0. Exception: sync_search_enable=1, because state RX_WAIT is entered. bit_cnt=0, timeout counter=0. Reset mid-packet drops the packet with no RX_Valid or RX_Error pulse.
- States:
  - RX_WAIT: sync_search_enable=1; all other outputs 0. On sync_detected, go to RX_DATA.
  - RX_DATA: RX_Active=1, unstuff_enable=1.
  - RX_EOP: RX_Active=1 for exactly one cycle, then go to RX_WAIT.
  - RX_ABORT: RX_Active=1, RX_Error=1. On eop_detected or line_idle, go to RX_WAIT.
- Latency:
  - RX_Active rises the cycle after the sync_detected pulse.
  - RX_Valid rises the cycle after the strobe carrying the 8th bit of a byte. RX_Data updates in the same cycle and holds until the next byte.
- Byte assembly: on each accepted strobe, shift_reg[bit_cnt] <= rx_bit and bit_cnt increments (3 bits, wraps 7->0). At the wrap, RX_Data <= assembled byte and RX_Valid pulses.
- No backpressure: the SIE must sample every RX_Valid pulse.
- EOP in RX_DATA:
  - bit_cnt==0: go to RX_EOP; no error.
  - bit_cnt!=0: partial-byte handling per the optional feature below.
- stuff_error in RX_DATA: go to RX_ABORT.
- Timeout counter:
  - Clears on every accepted strobe and on entering RX_DATA.
  - Increments each cycle otherwise.
  - Reaching TIMEOUT_CYC: go to RX_ABORT.
- Simultaneous events in RX_DATA, highest priority first:
  1. stuff_error: bit discarded, go to RX_ABORT.
  2. eop_detected: bit discarded.
  3. rx_bit_strobe.
- Ignored events:
  - sync_detected in any state other than RX_WAIT.
  - rx_bit_strobe outside RX_DATA.
  - eop_detected in RX_WAIT.
- Exits to RX_WAIT: RX_Active and RX_Error fall together on the cycle after the exit condition. The partial byte is discarded and bit_cnt clears on every entry to RX_WAIT.
- Illegal state encodings return to RX_WAIT.

Optional Feature:
UTMI_RX_DRIBBLE_EN
- Defined: EOP with bit_cnt in 1..7 (dribble bits) is treated as a normal end. The partial bits are discarded silently and the FSM goes to RX_EOP with no RX_Error.
- Undefined: EOP with bit_cnt!=0 goes to RX_ABORT. RX_Error is asserted for one cycle with RX_Active, then both fall and the FSM returns to RX_WAIT.

Test Plan:
1. Good packet: sync_detected, then 16 strobes carrying 0x2D then 0xA5 (LSB first), then eop_detected -> RX_Active high from the cycle after sync. RX_Valid pulses twice, RX_Data=0x2D then 0xA5. RX_Active falls 2 cycles after eop. RX_Error stays 0.
2. Stuff error after 11 bits -> at most one RX_Valid (first byte only). RX_Error=1 and RX_Active=1 until line_idle=1. Both then fall the next cycle, and sync_search_enable returns to 1.
3. Timeout, TIMEOUT_CYC=8: 3 strobes, then silence -> RX_Error asserts exactly 8 cycles after the last strobe. No RX_Valid.
4. Partial byte, 8+3 bits then EOP -> without UTMI_RX_DRIBBLE_EN: one RX_Valid, then a 1-cycle RX_Error. With UTMI_RX_DRIBBLE_EN: one RX_Valid, RX_Error stays 0.
5. Simultaneous events: the 8th bit's strobe coincides with eop_detected -> no RX_Valid for that byte; the EOP is handled with bit_cnt treated as 7. Separately, sync_detected during RX_DATA -> ignored, byte stream continues unchanged.
6. Rst asserted mid-byte (bit_cnt=5) -> all outputs 0 except sync_search_enable=1. After release, a new packet 0x3C is received correctly.
